// File: rtl/rad_monitor_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rad_monitor_fifo_arbiter
// Purpose  : Round-robin arbiter that shares one readout FIFO between several
//            radiation monitors. Each grant covers exactly one record, which
//            is preceded by a header word {4'hA, source index}. Sources that
//            are not granted are held off through their full inputs.
// Revision : 1.0 - initial release
// ============================================================================
module rad_monitor_fifo_arbiter #(
  parameter int G_SOURCES      = 4,
  parameter int G_DATA_WIDTH   = 8,
  parameter int G_RECORD_WORDS = 5,
  parameter int G_TIMEOUT      = 15
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   enable_i,
  input  logic [G_SOURCES-1:0]                   src_write_i,
  input  logic [G_SOURCES-1:0][G_DATA_WIDTH-1:0] src_data_i,
  output logic [G_SOURCES-1:0]                   src_full_o,
  output logic                                   fifo_write_o,
  output logic [G_DATA_WIDTH-1:0]                fifo_data_o,
  input  logic                                   fifo_full_i,
  output logic [3:0]                             active_src_o,
  output logic                                   busy_o,
  output logic [15:0]                            records_o,
  output logic [15:0]                            timeouts_o
);

  localparam int PTR_W  = (G_SOURCES > 1) ? $clog2(G_SOURCES) : 1;
  localparam int WCNT_W = (G_RECORD_WORDS > 1) ? $clog2(G_RECORD_WORDS) : 1;
  localparam int TMR_W  = $clog2(G_TIMEOUT + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(G_SOURCES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(G_RECORD_WORDS - 1);
  localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(G_TIMEOUT);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_PASS   = 2'd2;
  localparam logic [1:0] ST_NEXT   = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [PTR_W-1:0]  ptr_q,      ptr_d;
  logic [WCNT_W-1:0] wcnt_q,     wcnt_d;
  logic [TMR_W-1:0]  tmr_q,      tmr_d;
  logic [15:0]       records_q,  records_d;
  logic [15:0]       timeouts_q, timeouts_d;
  logic              busy_q,     busy_d;

  logic [3:0]              ptr_ext;
  logic                    sel_write;
  logic [G_DATA_WIDTH-1:0] sel_data;
  logic                    accept;
  logic [TMR_W-1:0]        tmr_inc;

  assign ptr_ext   = 4'(ptr_q);
  assign sel_write = src_write_i[ptr_q];
  assign sel_data  = src_data_i[ptr_q];
  // A word is taken only from the granted source and only when the FIFO has room.
  assign accept    = (state_q == ST_PASS) && sel_write && !fifo_full_i;
  assign tmr_inc   = tmr_q + TMR_W'(1);

  // State register: asynchronous reset truncates any record in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      tmr_q      <= '0;
      records_q  <= '0;
      timeouts_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      tmr_q      <= tmr_d;
      records_q  <= records_d;
      timeouts_q <= timeouts_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: record sequencing, idle timer and statistics counters.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wcnt_d     = wcnt_q;
    tmr_d      = tmr_q;
    records_d  = records_q;
    timeouts_d = timeouts_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (!fifo_full_i) begin
          wcnt_d  = '0;
          tmr_d   = '0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        // An accepted final word beats a simultaneous timeout.
        if (accept) begin
          tmr_d = '0;
          if (wcnt_q == WCNT_LAST) begin
            records_d = (records_q == CNT_MAX) ? records_q : records_q + 16'd1;
            state_d   = ST_NEXT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end else if (!fifo_full_i) begin
          // Backpressured cycles are not the source's fault and do not count.
          tmr_d = tmr_inc;
          if (tmr_inc == TMR_LIMIT) begin
            timeouts_d = (timeouts_q == CNT_MAX) ? timeouts_q : timeouts_q + 16'd1;
            state_d    = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        state_d = enable_i ? ST_HEADER : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_HEADER) || (state_d == ST_PASS);
  end

  // Output decode: header word in HEADER, zero-latency pass-through in PASS.
  always_comb begin
    src_full_o   = '1;
    fifo_write_o = 1'b0;
    fifo_data_o  = '0;
    case (state_q)
      ST_HEADER: begin
        if (!fifo_full_i) begin
          fifo_write_o = 1'b1;
          fifo_data_o  = G_DATA_WIDTH'({4'hA, ptr_ext});
        end
      end
      ST_PASS: begin
        src_full_o[ptr_q] = fifo_full_i;
        fifo_write_o      = accept;
        if (accept) fifo_data_o = sel_data;
      end
      default: begin
      end
    endcase
  end

  assign active_src_o = ptr_ext;
  assign busy_o       = busy_q;
  assign records_o    = records_q;
  assign timeouts_o   = timeouts_q;

endmodule
`default_nettype wire

// File: tb/tb_rad_monitor_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rad_monitor_fifo_arbiter
// Purpose  : Directed bench for rad_monitor_fifo_arbiter. Four model monitors
//            emit {source, sequence} words; expected FIFO words are queued
//            when records are scheduled and popped on every FIFO write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rad_monitor_fifo_arbiter;

  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [NS-1:0]    src_write;
  logic [NS-1:0][7:0] src_data;
  logic [NS-1:0]    src_full;
  logic             fifo_write;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic [3:0]       active_src;
  logic             busy;
  logic [15:0]      records;
  logic [15:0]      timeouts;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [3:0] cnt  [NS];
  logic [3:0] ecnt [NS];
  int         budget [NS];
  bit         pulse [NS];

  logic       s_wr;
  logic [7:0] s_data;
  logic [3:0] s_full;

  rad_monitor_fifo_arbiter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .src_write_i  (src_write),
    .src_data_i   (src_data),
    .src_full_o   (src_full),
    .fifo_write_o (fifo_write),
    .fifo_data_o  (fifo_data),
    .fifo_full_i  (fifo_full),
    .active_src_o (active_src),
    .busy_o       (busy),
    .records_o    (records),
    .timeouts_o   (timeouts)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int s = 0; s < NS; s++) begin
      src_write[s] = (budget[s] != 0);
      src_data[s]  = pulse[s] ? 8'h55 : {4'(s), cnt[s]};
    end
  endtask

  task automatic push_record(input int s, input int n);
    q.push_back({4'hA, 4'(s)});
    for (int i = 0; i < n; i++) begin
      q.push_back({4'(s), ecnt[s]});
      ecnt[s] = ecnt[s] + 4'd1;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cyc();
    logic [7:0] exp;
    drive_srcs();
    #1;
    s_wr   = fifo_write;
    s_data = fifo_data;
    s_full = src_full;
    if (s_wr) begin
      if (q.size() == 0) begin
        chk("write_unexpected", s_wr, 1'b0);
      end else begin
        exp = q.pop_front();
        chk("fifo_data", s_data, exp);
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (src_write[s] && !s_full[s]) begin
        cnt[s] = cnt[s] + 4'd1;
        if (budget[s] > 0) budget[s] = budget[s] - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int idle_nf;
    int it;
    logic [15:0] rec_before;

    rst_n     = 1'b0;
    enable    = 1'b0;
    fifo_full = 1'b0;
    for (int s = 0; s < NS; s++) begin
      cnt[s] = '0; ecnt[s] = '0; budget[s] = -1; pulse[s] = 1'b0;
    end
    drive_srcs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_src_full", src_full, 4'hF);
    chk("rst_fifo_write", fifo_write, 1'b0);
    chk("rst_fifo_data", fifo_data, 8'h00);
    chk("rst_active", active_src, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_records", records, 16'd0);
    chk("rst_timeouts", timeouts, 16'd0);
    @(negedge clk);

    // Round-robin over all four sources without backpressure.
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc();
    chk("busy_after_idle", busy, 1'b1);
    for (int s = 0; s < NS; s++) push_record(s, 5);
    repeat (26) cyc();
    chk("records_at_26", records, 16'd3);
    cyc();
    chk("records_at_27", records, 16'd4);
    chk("busy_in_next", busy, 1'b0);
    chk("active_in_next", active_src, 4'd3);
    cyc();
    chk("queue_rr", q.size(), 0);
    chk("active_wrap", active_src, 4'd0);

    // Readout FIFO full for three cycles in the middle of a record.
    push_record(0, 5);
    repeat (3) cyc();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_write", s_wr, 1'b0);
      chk("stall_full0", s_full[0], 1'b1);
      chk("stall_data", s_data, 8'h00);
    end
    fifo_full = 1'b0;
    repeat (4) cyc();
    chk("queue_stall", q.size(), 0);
    chk("records_stall", records, 16'd5);

    push_record(1, 5);
    repeat (7) cyc();

    // Source 2 stalls after two words; a backpressure gap must not count.
    budget[2] = 2;
    push_record(2, 2);
    repeat (3) cyc();
    idle_nf = 0;
    it      = 0;
    while (timeouts == 16'd0 && it < 40) begin
      fifo_full = (it == 4 || it == 5);
      cyc();
      if (!fifo_full) idle_nf++;
      it++;
    end
    fifo_full = 1'b0;
    chk("timeouts_1", timeouts, 16'd1);
    chk("idle_cycles", idle_nf, 15);
    chk("timeout_iters", it, 17);
    chk("records_after_to", records, 16'd6);
    chk("busy_after_to", busy, 1'b0);
    chk("active_after_to", active_src, 4'd2);
    budget[2] = -1;
    push_record(3, 5);
    cyc();
    chk("next_full", s_full, 4'hF);

    // Non-granted source 0 presents 8'h55 while source 3 is granted.
    cyc();
    rec_before = records;
    pulse[0] = 1'b1;
    cyc();
    pulse[0] = 1'b0;
    chk("pulse_records", records, rec_before);
    repeat (5) cyc();
    chk("records_after_pulse", records, 16'd7);
    chk("queue_pulse", q.size(), 0);

    push_record(0, 5);
    repeat (7) cyc();

    // Enable dropped during word 3 of source 1.
    push_record(1, 5);
    repeat (3) cyc();
    enable = 1'b0;
    repeat (3) cyc();
    cyc();
    chk("dis_next_full", s_full, 4'hF);
    chk("dis_busy", busy, 1'b0);
    chk("dis_active", active_src, 4'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_write", s_wr, 1'b0);
      chk("idle_full", s_full, 4'hF);
    end
    chk("records_dis", records, 16'd9);
    chk("queue_dis", q.size(), 0);

    // Re-enable, then reset in the middle of the source 2 record.
    enable = 1'b1;
    push_record(2, 5);
    repeat (4) cyc();
    drive_srcs();
    #1;
    chk("pre_rst_write", fifo_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write", fifo_write, 1'b0);
    chk("rst_mid_full", src_full, 4'hF);
    chk("rst_mid_records", records, 16'd0);
    chk("rst_mid_busy", busy, 1'b0);
    q.delete();
    ecnt[2] = ecnt[2] - 4'd3;
    repeat (2) cyc();
    rst_n = 1'b1;
    push_record(0, 5);
    cyc();
    repeat (7) cyc();
    chk("post_rst_records", records, 16'd1);
    chk("post_rst_timeouts", timeouts, 16'd0);
    chk("queue_post_rst", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
